bcd_count_gen: RTL and testbench
================================

# bcd_count_gen

Parametrised successor to the free-running display number generator. Produces a DIGITS-wide packed BCD value that steps once per CLK_DIV enabled clocks, for the seven-segment scan driver. Adds up/down counting, synchronous clear and load, wrap or saturate limit handling, and single-cycle step/wrap strobes.

## Interface
- CLK_DIV, default 500_000: clk cycles per step; legal range ≥ 2. Prescaler width is $clog2(CLK_DIV).
- DIGITS, default 4: number of BCD digits; legal range 1–8.
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; low freezes prescaler and value.
- up_dn  in  1  1 = count up, 0 = count down; sampled at the step edge.
- sat_mode  in  1  0 = wrap at limits, 1 = saturate at limits.
- clr  in  1  synchronous clear of value and prescaler.
- load  in  1  synchronous load of load_val; also clears the prescaler.
- load_val  in  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- bcd_out  out  4*DIGITS  current value, packed BCD, digit 0 least significant.
- step_pulse  out  1  high for one cycle when bcd_out changes because of a step.
- wrap_pulse  out  1  high for one cycle when a step wraps 9…9→0 (up) or 0→9…9 (down).
- at_limit  out  1  high while the value is at the limit for the current direction: all 9s when up_dn=1, all 0s when up_dn=0. Combinational from registered value and up_dn.

## Operation
- Reset values: prescaler 0, bcd_out 0, step_pulse 0, wrap_pulse 0. at_limit follows up_dn (1 if up_dn=0).
- Prescaler counts 0…CLK_DIV-1 on each edge with en=1; holds when en=0.
- The step edge is the enabled edge on which the prescaler equals CLK_DIV-1. On that edge the prescaler returns to 0 and the value steps.
- Up step: digit 0 +1. A digit at 9 becomes 0 and carries into the next digit. Carry out of the top digit is a wrap.
- Down step: digit 0 −1. A digit at 0 becomes 9 and borrows from the next digit. Borrow out of the top digit is a wrap.
- Wrap mode (sat_mode=0): at the limit, the step wraps and wrap_pulse=1 with step_pulse=1.
- Saturate mode (sat_mode=1): at the limit, the value holds and no pulses are asserted. The prescaler still recycles.
- Priority, highest first: clr > load > step. The priority order applies to the same edge.
  - clr: value 0, prescaler 0, no pulses. clr acts regardless of en.
  - load: value = load_val, prescaler 0, no pulses. load acts regardless of en.
  - Each load_val digit greater than 9 is clamped to 9 independently. Example: 0xA3 loads as 0x93.
- The value only ever holds legal BCD, digits 0–9.
- Changing up_dn between steps takes effect at the next step edge, not mid-period. There is no prescaler reset on a direction change.
- An rst_n assertion at any point returns all state to reset values immediately, with no clock required.

## Timing
- After reset release with en held at 1, the first step is visible on bcd_out after the CLK_DIV-th rising edge. Subsequent steps occur every CLK_DIV edges.
- Each en-low cycle stretches the current step period by one cycle.
- step_pulse and wrap_pulse are registered. Both are high in the same cycle that the new bcd_out is first visible.
- clr/load latency: one edge. New bcd_out is visible after the edge where the control is sampled high.
- After clr or load, the next step occurs CLK_DIV enabled edges later.
- All outputs except at_limit are registered. No combinational path exists from inputs to bcd_out, step_pulse or wrap_pulse.

## Test plan
Bench parameters: CLK_DIV=4, DIGITS=2.
1. Reset, en=1, up_dn=1, sat_mode=0, run 400 cycles.
   - bcd_out goes 0x00, 0x01 … 0x09, 0x10 … 0x99, 0x00, stepping every 4 edges; no hex digits ever appear.
   - A single wrap_pulse coincides with 0x99→0x00.
2. Load 0x02, then up_dn=0, sat_mode=0.
   - Steps are 0x01, 0x00, 0x99.
   - wrap_pulse fires on 0x00→0x99; at_limit=1 while the value is 0x00.
3. sat_mode=1, load 0x98, up_dn=1, run 20 cycles.
   - Value goes 0x98→0x99, then holds; one step_pulse only.
   - at_limit=1 and wrap_pulse never fires.
4. Toggle en low for 3 cycles mid-period.
   - The step is delayed by exactly 3 cycles and the value is unchanged during the freeze.
5. Assert clr and load together with load_val=0x55 on a step edge.
   - bcd_out=0x00 next cycle, no pulses; the next step is 4 edges later.
   - Separately, load 0xAB: the result is 0x99.
6. Assert rst_n low asynchronously between clock edges at value 0x47.
   - bcd_out=0x00 and pulses=0 immediately.
   - After release, the first step to 0x01 comes after 4 edges.

Source files
------------

// File: rtl/bcd_count_gen.sv
// rtl/bcd_count_gen.sv - prescaled packed-BCD up/down counter with wrap/saturate limits
// Feeds the seven-segment scan driver; steps once per CLK_DIV enabled clocks.
module bcd_count_gen #(
  parameter int CLK_DIV = 500_000,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  step_pulse,
  output logic                  wrap_pulse,
  output logic                  at_limit
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int W  = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [W-1:0]  ALL_NINES  = {DIGITS{4'd9}};

  logic [PW-1:0] presc;
  logic [W-1:0]  stepped;
  logic [W-1:0]  clamped;
  logic          carry;
  logic [3:0]    d;

  assign at_limit = up_dn ? (bcd_out == ALL_NINES) : (bcd_out == '0);

  // Ripple carry/borrow through the digits; carry left over from the top digit is a wrap.
  always_comb begin
    stepped = bcd_out;
    clamped = '0;
    carry   = 1'b1;
    d       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd_out[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (d == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      bcd_out    <= '0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      if (clr) begin
        presc   <= '0;
        bcd_out <= '0;
      end else if (load) begin
        presc   <= '0;
        bcd_out <= clamped;
      end else if (en) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          // Saturating at the limit holds the value but the prescaler keeps recycling.
          if (!(sat_mode && at_limit)) begin
            bcd_out    <= stepped;
            step_pulse <= 1'b1;
            wrap_pulse <= carry;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_count_gen.sv
// tb/tb_bcd_count_gen.sv - self-checking bench for bcd_count_gen against a decimal reference model
module tb_bcd_count_gen;

  localparam int CLK_DIV = 4;
  localparam int DIGITS  = 2;
  localparam int W       = 4 * DIGITS;
  localparam int MAXV    = 10 ** DIGITS - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         sat_mode;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] bcd_out;
  logic         step_pulse;
  logic         wrap_pulse;
  logic         at_limit;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_val  = 0;
  int m_cnt  = 0;
  bit e_step = 0;
  bit e_wrap = 0;
  int n_wrap = 0;
  int n_step = 0;

  bcd_count_gen #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val), .bcd_out(bcd_out),
    .step_pulse(step_pulse), .wrap_pulse(wrap_pulse), .at_limit(at_limit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] lv);
    int res, mul, dg;
    res = 0;
    mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      dg = int'(lv[4*i +: 4]);
      if (dg > 9) dg = 9;
      res += dg * mul;
      mul *= 10;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".bcd"},  32'(bcd_out), 32'(to_bcd(m_val)));
    check({tag, ".step"}, 32'(step_pulse), 32'(e_step));
    check({tag, ".wrap"}, 32'(wrap_pulse), 32'(e_wrap));
    check({tag, ".lim"},  32'(at_limit), 32'(up_dn ? (m_val == MAXV) : (m_val == 0)));
  endtask

  // Model advances from the inputs as they stand before the edge, then DUT is sampled 1 ns after.
  task automatic tick(input string tag);
    bit lim;
    e_step = 0;
    e_wrap = 0;
    if (clr) begin
      m_val = 0; m_cnt = 0;
    end else if (load) begin
      m_val = clamp_val(load_val); m_cnt = 0;
    end else if (en) begin
      if (m_cnt == CLK_DIV - 1) begin
        m_cnt = 0;
        lim = up_dn ? (m_val == MAXV) : (m_val == 0);
        if (!(sat_mode && lim)) begin
          m_val  = up_dn ? (m_val + 1) % (MAXV + 1) : (m_val + MAXV) % (MAXV + 1);
          e_step = 1;
          e_wrap = lim;
        end
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (wrap_pulse) n_wrap++;
    if (step_pulse) n_step++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = '0;
    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    // 1: full up-count cycle with one wrap at 99 -> 00
    n_wrap = 0;
    for (int i = 0; i < 400; i++) tick("t1");
    check("t1.wrap_count", 32'(n_wrap), 32'd1);
    check("t1.final", 32'(bcd_out), 32'h00);

    // 2: down count from 02 through 00 into 99
    load = 1'b1; load_val = 8'h02; up_dn = 1'b0;
    tick("t2.load");
    load = 1'b0;
    n_wrap = 0;
    for (int i = 0; i < 12; i++) tick("t2");
    check("t2.final", 32'(bcd_out), 32'h99);
    check("t2.wrap_count", 32'(n_wrap), 32'd1);

    // 3: saturate at 99
    sat_mode = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h98;
    tick("t3.load");
    load = 1'b0;
    n_step = 0; n_wrap = 0;
    for (int i = 0; i < 20; i++) tick("t3");
    check("t3.step_count", 32'(n_step), 32'd1);
    check("t3.wrap_count", 32'(n_wrap), 32'd0);
    check("t3.limit", 32'(at_limit), 32'd1);

    // 4: three-cycle freeze mid-period
    sat_mode = 1'b0; load = 1'b1; load_val = 8'h30;
    tick("t4.load");
    load = 1'b0;
    tick("t4.a"); tick("t4.b");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("t4.frz");
      check("t4.frz_val", 32'(bcd_out), 32'h30);
    end
    en = 1'b1;
    tick("t4.c");
    check("t4.pre_step", 32'(bcd_out), 32'h30);
    tick("t4.d");
    check("t4.step", 32'(bcd_out), 32'h31);

    // 5: clr and load together on a step edge, then clamp of hex load
    for (int i = 0; i < CLK_DIV && m_cnt != CLK_DIV - 1; i++) tick("t5.align");
    check("t5.aligned", 32'(m_cnt), 32'(CLK_DIV - 1));
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    tick("t5.clr");
    check("t5.clr_val", 32'(bcd_out), 32'h00);
    clr = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) tick("t5.wait");
    check("t5.pre_step", 32'(bcd_out), 32'h00);
    tick("t5.step");
    check("t5.step_val", 32'(bcd_out), 32'h01);
    load = 1'b1; load_val = 8'hAB;
    tick("t5.hex");
    check("t5.clamp", 32'(bcd_out), 32'h99);
    load = 1'b0;

    // 6: asynchronous reset between edges at 47
    load = 1'b1; load_val = 8'h47;
    tick("t6.load");
    load = 1'b0;
    tick("t6.a");
    #2;
    rst_n = 1'b0;
    #1;
    m_val = 0; m_cnt = 0; e_step = 0; e_wrap = 0;
    check_outputs("t6.async");
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("t6.wait");
    check("t6.pre_step", 32'(bcd_out), 32'h00);
    tick("t6.step");
    check("t6.first", 32'(bcd_out), 32'h01);

    // Randomised mix of controls against the model
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) sat_mode = $urandom_range(0, 1) == 1;
      clr      = ($urandom_range(0, 60) == 0);
      load     = ($urandom_range(0, 30) == 0);
      load_val = W'($urandom);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
